// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared defaults, FSM encoding and fetch entry layout for the fetch buffer
// Contents:
//   IF_ADDR_W / IF_INST_W  default PC and instruction widths
//   IF_RESET_PC            default PC after reset
//   if_state_e             fetch FSM states (RUN / DRAIN / HALT)
//   if_entry_t             buffered {pc, inst, adel} entry at default widths
package if_pkg;

  localparam int          IF_ADDR_W   = 32;
  localparam int          IF_INST_W   = 32;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,  // normal fetching
    ST_DRAIN = 2'd1,  // stale responses still owed by memory
    ST_HALT  = 2'd2   // address-error entry issued, waiting for flush/redirect
  } if_state_e;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_INST_W-1:0] inst;
    logic                 adel;
  } if_entry_t;

endpackage

// File: rtl/if_inst_fifo.sv
// rtl/if_inst_fifo.sv - synchronous power-of-two FIFO with clear, used for fetch buffer and pending-address queue
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   clr_i    synchronous clear, overrides push/pop
//   push_i   write data_i (ignored when full unless popping in the same cycle)
//   data_i   write data
//   pop_i    advance head (ignored when empty)
//   data_o   head data (meaningful when count_o != 0)
//   count_o  occupancy, 0..DEPTH
module if_inst_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_buf.sv
// rtl/if_fetch_buf.sv - instruction fetch stage with multiple outstanding requests and a DEPTH-entry buffer to ID
// Optional feature: define IF_ADEL_CHK_EN to turn misaligned fetch PCs into an address-error
// entry (id_adel=1) and halt fetching until flush/redirect.
// Ports:
//   cpu_clk_50M      clock
//   cpu_rst_n        asynchronous active-low reset
//   flush            exception flush, highest priority, restarts at cp0_excaddr
//   cp0_excaddr      exception handler address
//   redirect_valid   taken branch/jump from ID, restarts at redirect_addr
//   redirect_addr    branch/jump target
//   ice / iaddr      memory request valid / address (RESET_PC while idle)
//   irdy             memory accepts the request this cycle
//   inst_valid_in    in-order response valid
//   inst_in          response instruction
//   id_valid         buffer head valid
//   id_ready         ID consumes the head
//   id_pc / id_inst  head PC / instruction (0 when id_valid=0)
//   id_pc_plus_4     id_pc + 4, wrapping
//   id_adel          head carries an address-error flag
module if_fetch_buf
  import if_pkg::*;
#(
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter int                INST_W   = IF_INST_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] cp0_excaddr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              ice,
  output logic [ADDR_W-1:0] iaddr,
  input  logic              irdy,
  input  logic              inst_valid_in,
  input  logic [INST_W-1:0] inst_in,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc_plus_4,
  output logic              id_adel
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Same layout as if_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              adel;
  } entry_t;

  localparam int EW = $bits(entry_t);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     discard_q, discard_d;

  logic              kill;
  logic [CW-1:0]     pending;
  logic [CW:0]       in_use;
  logic              credit_ok;
  logic              resp_keep;
  logic              resp_drop;
  logic              accept;
  logic              misaligned;
  logic              adel_push;

  logic [CW-1:0]     pq_count;
  logic [ADDR_W-1:0] pq_head;

  logic              buf_push;
  logic              buf_pop;
  logic [CW-1:0]     buf_count;
  entry_t            buf_wdata;
  entry_t            buf_head;
  logic [EW-1:0]     buf_wvec;
  logic [EW-1:0]     buf_rvec;

  assign kill = flush | redirect_valid;

  // Responses still owed by memory: the ones to be thrown away plus the ones
  // whose PC is waiting in the pending-address queue.
  assign pending   = discard_q + pq_count;
  assign in_use    = {1'b0, pending} + {1'b0, buf_count};
  // Every outstanding request has a reserved buffer slot, so a kept response
  // can never find the buffer full.
  assign credit_ok = (in_use < (CW+1)'(DEPTH));

  assign resp_keep = inst_valid_in && (discard_q == '0);
  assign resp_drop = inst_valid_in && (discard_q != '0);

`ifdef IF_ADEL_CHK_EN
  assign misaligned = (fetch_pc_q[1:0] != 2'b00);
  // The error entry goes in only after every older response has landed, so it
  // stays in program order behind them.
  assign adel_push  = misaligned && (state_q != ST_HALT) && !kill &&
                      credit_ok && (pending == '0);
`else
  assign misaligned = 1'b0;
  assign adel_push  = 1'b0;
`endif

  assign ice    = cpu_rst_n && !kill && credit_ok && !misaligned && (state_q != ST_HALT);
  assign iaddr  = ice ? fetch_pc_q : RESET_PC;
  assign accept = ice && irdy;

  always_comb begin
    buf_wdata = '0;
    if (adel_push) begin
      buf_wdata.pc   = fetch_pc_q;
      buf_wdata.inst = '0;
      buf_wdata.adel = 1'b1;
    end else begin
      buf_wdata.pc   = pq_head;
      buf_wdata.inst = inst_in;
      buf_wdata.adel = 1'b0;
    end
  end

  assign buf_push = resp_keep || adel_push;
  assign buf_pop  = id_valid && id_ready;
  assign buf_wvec = buf_wdata;
  assign buf_head = entry_t'(buf_rvec);

  // Next PC, discard count and FSM state.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    state_d    = state_q;

    if (flush) begin
      fetch_pc_d = cp0_excaddr;
    end else if (redirect_valid) begin
      fetch_pc_d = redirect_addr;
    end else if (accept) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end

    if (kill) begin
      // A response landing this cycle is already accounted for and is not owed.
      discard_d = pending - CW'(inst_valid_in);
    end else begin
      discard_d = discard_q - CW'(resp_drop);
    end

    if (kill) begin
      state_d = (discard_d != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (adel_push) state_d = ST_HALT;
        ST_DRAIN: if (discard_d == '0) state_d = ST_RUN;
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  // PCs of live requests, popped in order as their responses arrive.
  if_inst_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_pend_q (
    .clk_i   (cpu_clk_50M),
    .rst_ni  (cpu_rst_n),
    .clr_i   (kill),
    .push_i  (accept),
    .data_i  (fetch_pc_q),
    .pop_i   (resp_keep),
    .data_o  (pq_head),
    .count_o (pq_count)
  );

  // {pc, inst, adel} entries waiting for ID.
  if_inst_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_buf_q (
    .clk_i   (cpu_clk_50M),
    .rst_ni  (cpu_rst_n),
    .clr_i   (kill),
    .push_i  (buf_push),
    .data_i  (buf_wvec),
    .pop_i   (buf_pop),
    .data_o  (buf_rvec),
    .count_o (buf_count)
  );

  assign id_valid     = (buf_count != '0);
  assign id_pc        = id_valid ? buf_head.pc : '0;
  assign id_inst      = id_valid ? buf_head.inst : '0;
  assign id_pc_plus_4 = id_valid ? (buf_head.pc + ADDR_W'(4)) : '0;
  // Only the address-error path ever writes adel=1.
  assign id_adel      = id_valid && buf_head.adel;

endmodule
